keypad_entry: RTL and testbench

- Input-side counterpart to the seven-segment output path.
- Services the processor's Input instruction. While the instruction is pending, the CPU is stalled and the user builds a decimal number of up to 8 digits:
  - set a digit on sw[3:0], press KEY_DIGIT to append it;
  - press KEY_ENTER to commit.
- The committed value is handed to the register-file write path with a one-cycle valid pulse, and the stall is released.
- entry_value and digit_count are live outputs, so the display block can echo digits as they are typed.

---
 rtl/io_pkg.sv | 7 +
 rtl/key_debounce.sv | 34 +++
 rtl/keypad_entry.sv | 78 +++++++
 tb/tb_keypad_entry.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// io_pkg: constants and FSM encoding shared by the keypad input path, display and CPU
package io_pkg;
  typedef enum logic [1:0] {IDLE, ENTRY, DONE} io_state_t;
  localparam int DIGIT_MAX           = 9;
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_DATA_W          = 32;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-FF synchronizer, stability counter and one-cycle press pulse for an active-low key
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  logic s1, s2, s3, deb;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
      deb <= 1'b1;
      cnt <= '0;
      press <= 1'b0;
    end else begin
      s1 <= key_n;
      s2 <= s1;
      s3 <= s2;
      press <= 1'b0;
      if (s2 != s3) cnt <= '0;
      else if (cnt != CW'(DEBOUNCE_CYCLES - 1)) cnt <= cnt + 1'b1;
      else begin
        press <= deb & ~s2;
        deb <= s2;
      end
    end
  end
endmodule

// File: rtl/keypad_entry.sv
// keypad_entry: decimal keypad entry servicing the CPU Input instruction.
// Define SIGNED_ENTRY_EN to let sw[9] negate the committed value.
module keypad_entry import io_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int MAX_DIGITS      = 8,
  parameter int DATA_W          = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              input_req,
  input  logic              key_digit_n,
  input  logic              key_enter_n,
  input  logic [9:0]        sw,
  output logic              stall,
  output logic              input_valid,
  output logic [DATA_W-1:0] input_data,
  output logic [DATA_W-1:0] entry_value,
  output logic [3:0]        digit_count
);
  io_state_t state, nstate;
  logic [DATA_W-1:0] acc, nacc, ndata, dacc, cval;
  logic [3:0] cnt, ncnt, dcnt;
  logic dig_p, ent_p, dig_ok, unused_sw;
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dig (.clk, .reset, .key_n(key_digit_n), .press(dig_p));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ent (.clk, .reset, .key_n(key_enter_n), .press(ent_p));
  assign unused_sw = ^sw[9:4];
  // a digit arriving with enter is folded in before the commit
  always_comb begin
    dig_ok = dig_p && sw[3:0] <= 4'(DIGIT_MAX) && cnt < 4'(MAX_DIGITS);
    dacc = dig_ok ? (acc << 3) + (acc << 1) + DATA_W'(sw[3:0]) : acc;
    dcnt = dig_ok ? cnt + 4'd1 : cnt;
`ifdef SIGNED_ENTRY_EN
    cval = sw[9] ? -dacc : dacc;
`else
    cval = dacc;
`endif
    nstate = state;
    nacc = acc;
    ncnt = cnt;
    ndata = input_data;
    case (state)
      IDLE: begin
        nacc = '0;
        ncnt = '0;
        nstate = input_req ? ENTRY : IDLE;
      end
      ENTRY: begin
        if (!input_req) nstate = IDLE;
        else begin
          nacc = dacc;
          ncnt = dcnt;
          if (ent_p) begin
            ndata = cval;
            nstate = DONE;
          end
        end
      end
      default: nstate = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      input_data <= '0;
    end else begin
      state <= nstate;
      acc <= nacc;
      cnt <= ncnt;
      input_data <= ndata;
    end
  end
  assign stall = reset && input_req && state != DONE;
  assign input_valid = state == DONE;
  assign entry_value = acc;
  assign digit_count = cnt;
endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: scoreboard bench for keypad_entry with a short debounce window
module tb_keypad_entry;
  logic clk = 0, reset = 0, input_req = 0, key_digit_n = 1, key_enter_n = 1;
  logic [9:0] sw = '0;
  logic stall, input_valid;
  logic [31:0] input_data, entry_value;
  logic [3:0] digit_count;
  int tests = 0, fails = 0, vcount = 0, exp_valid = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_acc, last_data;
  int exp_cnt;
  logic prev_valid = 0;

  keypad_entry #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .input_req(input_req), .key_digit_n(key_digit_n),
    .key_enter_n(key_enter_n), .sw(sw), .stall(stall), .input_valid(input_valid),
    .input_data(input_data), .entry_value(entry_value), .digit_count(digit_count));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (input_valid) begin
      vcount++;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_empty: input_valid with data %0d but nothing expected", input_data);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        if (input_data !== e) begin
          fails++;
          $display("FAIL commit_data: got %0h expected %0h", input_data, e);
        end
      end
      tests++;
      if (stall !== 1'b0) begin fails++; $display("FAIL stall_in_done: got %b expected 0", stall); end
      tests++;
      if (prev_valid) begin fails++; $display("FAIL valid_width: input_valid high 2 cycles, got 1 expected 0"); end
    end
    prev_valid <= input_valid;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic keys(input bit dig, input bit ent, input logic [3:0] d);
    sw[3:0] = d;
    if (dig) key_digit_n = 0;
    if (ent) key_enter_n = 0;
    cyc(12);
    key_digit_n = 1;
    key_enter_n = 1;
    cyc(12);
  endtask

  task automatic check_entry(input string name);
    tests++;
    if (digit_count !== exp_cnt[3:0] || entry_value !== exp_acc) begin
      fails++;
      $display("FAIL %s: got count %0d value %0d expected count %0d value %0d",
               name, digit_count, entry_value, exp_cnt, exp_acc);
    end
  endtask

  task automatic start();
    input_req = 1;
    cyc(3);
    exp_acc = 0;
    exp_cnt = 0;
  endtask

  task automatic stop();
    input_req = 0;
    cyc(3);
  endtask

  task automatic digit(input logic [3:0] d);
    if (d <= 9 && exp_cnt < 8) begin
      exp_acc = exp_acc * 10 + 32'(d);
      exp_cnt++;
    end
    keys(1, 0, d);
    check_entry("digit");
  endtask

  task automatic commit_value(input logic [31:0] v);
    logic [31:0] c;
    c = (sw[9] && `ifdef SIGNED_ENTRY_EN 1 `else 0 `endif) ? -v : v;
    sb.push_back(c);
    last_data = c;
    exp_valid++;
  endtask

  task automatic enter();
    commit_value(exp_acc);
    keys(0, 1, 4'd0);
    tests++;
    if (vcount !== exp_valid) begin
      fails++;
      $display("FAIL valid_count: got %0d expected %0d", vcount, exp_valid);
    end
  endtask

  task automatic test_reset();
    cyc(2);
    tests++;
    if ({stall, input_valid, input_data, entry_value, digit_count} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %b %b %0h %0h %0d expected all 0",
               stall, input_valid, input_data, entry_value, digit_count);
    end
    reset = 1;
    last_data = 0;
    cyc(2);
  endtask

  task automatic test_basic();
    start();
    tests++;
    if (stall !== 1'b1) begin fails++; $display("FAIL stall_entry: got %b expected 1", stall); end
    digit(1);
    digit(2);
    digit(3);
    enter();
    cyc(2);
    exp_acc = 0;
    exp_cnt = 0;
    check_entry("back_to_back_clear");
    tests++;
    if (stall !== 1'b1) begin fails++; $display("FAIL stall_reentry: got %b expected 1", stall); end
    digit(8);
    enter();
    stop();
  endtask

  task automatic test_invalid_overflow();
    start();
    digit(11);
    digit(15);
    for (int i = 0; i < 9; i++) digit(9);
    enter();
    stop();
  endtask

  task automatic test_bounce();
    start();
    sw[3:0] = 5;
    for (int i = 0; i < 10; i++) begin
      key_digit_n = ~key_digit_n;
      cyc(2);
    end
    key_digit_n = 0;
    cyc(12);
    key_digit_n = 1;
    cyc(12);
    exp_acc = 5;
    exp_cnt = 1;
    check_entry("bounce");
    enter();
    stop();
  endtask

  task automatic test_abort_idle();
    exp_acc = 0;
    exp_cnt = 0;
    keys(1, 0, 4'd3);
    keys(0, 1, 4'd0);
    check_entry("idle_digit");
    tests++;
    if (vcount !== exp_valid) begin fails++; $display("FAIL idle_enter: got %0d valids expected %0d", vcount, exp_valid); end
    start();
    digit(2);
    digit(3);
    stop();
    exp_acc = 0;
    exp_cnt = 0;
    check_entry("abort_clear");
    tests++;
    if (vcount !== exp_valid || input_data !== last_data) begin
      fails++;
      $display("FAIL abort: got valids %0d data %0d expected valids %0d data %0d",
               vcount, input_data, exp_valid, last_data);
    end
  endtask

  task automatic test_simultaneous();
    start();
    digit(4);
    commit_value(47);
    keys(1, 1, 4'd7);
    tests++;
    if (vcount !== exp_valid) begin fails++; $display("FAIL simul_valid: got %0d expected %0d", vcount, exp_valid); end
    stop();
    start();
    enter();
    stop();
  endtask

  task automatic test_signed();
`ifdef SIGNED_ENTRY_EN
    start();
    digit(5);
    sw[9] = 1;
    enter();
    sw[9] = 0;
    stop();
    tests++;
    if (last_data !== 32'hFFFF_FFFB) begin fails++; $display("FAIL signed_model: got %0h expected fffffffb", last_data); end
`endif
  endtask

  task automatic test_reset_mid();
    start();
    digit(6);
    #3 reset = 0;
    #1;
    tests++;
    if ({stall, input_valid, input_data, entry_value, digit_count} !== '0) begin
      fails++;
      $display("FAIL reset_mid: got %b %b %0h %0h %0d expected all 0",
               stall, input_valid, input_data, entry_value, digit_count);
    end
    cyc(2);
    reset = 1;
    input_req = 0;
    cyc(3);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_invalid_overflow();
    test_bounce();
    test_abort_idle();
    test_simultaneous();
    test_signed();
    test_reset_mid();
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL sb_leftover: got %0d pending expected 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
